// File: rtl/lane_deskew.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lane_deskew : per-lane FIFOs that realign skewed parallel lanes into one  |
// |               aligned output word, with skew-timeout and overflow flags.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module lane_deskew #(
  parameter int WIDTH    = 8,
  parameter int NUB      = 4,
  parameter int DEPTH    = 8,
  parameter int MAX_SKEW = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUB-1:0]         in_valid,
  input  logic [WIDTH*NUB-1:0]   in_data,
  output logic [NUB-1:0]         in_ready,
  output logic                   out_valid,
  output logic [WIDTH*NUB-1:0]   out_data,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic                   err_skew,
  output logic [NUB-1:0]         err_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(MAX_SKEW + 1);
  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [SW-1:0] CNT_ONE = 1;
  localparam logic [SW-1:0] CNT_MAX = SW'(MAX_SKEW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t               state;
  logic [SW-1:0]        skew_cnt;
  logic [NUB-1:0]       empty;
  logic [NUB-1:0]       full;
  logic [WIDTH*NUB-1:0] rd_word;
  logic                 all_ne;
  logic                 partial;
  logic                 pop;

  assign all_ne   = ~|empty;
  assign partial  = ~&empty & ~all_ne;
  assign pop      = all_ne & (~out_valid | out_ready) & (state != ERR);
  assign in_ready = ~full;

  generate
    for (genvar j = 0; j < NUB; j++) begin : g_lane
      logic [WIDTH-1:0] mem [DEPTH];
      logic [AW:0]      wptr;
      logic [AW:0]      rptr;
      logic             ovf;
      logic             wr;

      // Extra pointer MSB distinguishes full from empty when the indices match.
      assign empty[j] = (wptr == rptr);
      assign full[j]  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
      assign wr       = in_valid[j] & ~full[j] & ~flush;
      assign rd_word[j*WIDTH +: WIDTH] = mem[rptr[AW-1:0]];
      assign err_ovf[j] = ovf;

      always_ff @(posedge clk) begin
        if (wr) begin
          mem[wptr[AW-1:0]] <= in_data[j*WIDTH +: WIDTH];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wptr <= '0;
          rptr <= '0;
          ovf  <= 1'b0;
        end else if (flush) begin
          wptr <= '0;
          rptr <= '0;
          ovf  <= 1'b0;
        end else begin
          if (wr) begin
            wptr <= wptr + PTR_ONE;
          end
          if (pop) begin
            rptr <= rptr + PTR_ONE;
          end
          if (in_valid[j] & full[j]) begin
            ovf <= 1'b1;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      skew_cnt  <= '0;
      err_skew  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      state     <= IDLE;
      skew_cnt  <= '0;
      err_skew  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= rd_word;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (partial) begin
            state    <= WAIT;
            skew_cnt <= CNT_ONE;
          end
        end
        WAIT: begin
          if (!partial) begin
            state    <= IDLE;
            skew_cnt <= '0;
          end else if (skew_cnt == CNT_MAX) begin
            state    <= ERR;
            err_skew <= 1'b1;
          end else begin
            skew_cnt <= skew_cnt + CNT_ONE;
          end
        end
        default: begin
          // ERR is left only through flush or reset.
          state <= ERR;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lane_deskew.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lane_deskew : randomized and directed bench against a queue model.    |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_lane_deskew;

  localparam int WIDTH    = 8;
  localparam int NUB      = 4;
  localparam int DEPTH    = 8;
  localparam int MAX_SKEW = 6;
  localparam int DW       = WIDTH * NUB;
  localparam int NWRAP    = 3 * DEPTH;

  logic           clk;
  logic           rst_n;
  logic [NUB-1:0] in_valid;
  logic [DW-1:0]  in_data;
  logic [NUB-1:0] in_ready;
  logic           out_valid;
  logic [DW-1:0]  out_data;
  logic           out_ready;
  logic           flush;
  logic           err_skew;
  logic [NUB-1:0] err_ovf;

  lane_deskew #(
    .WIDTH(WIDTH), .NUB(NUB), .DEPTH(DEPTH), .MAX_SKEW(MAX_SKEW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush(flush), .err_skew(err_skew), .err_ovf(err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one queue per lane, an output slot, sticky flags and
  // the length of the current run of partially occupied cycles.
  logic [WIDTH-1:0] mq [NUB][$];
  bit               m_ov;
  logic [DW-1:0]    m_od;
  bit               m_err;
  int               m_run;
  logic [NUB-1:0]   m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] word(input int k);
    logic [DW-1:0] w;
    w = '0;
    for (int j = 0; j < NUB; j++) w[j*WIDTH +: WIDTH] = WIDTH'(16 * j + k);
    return w;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NUB; j++) mq[j].delete();
    m_ov = 0; m_od = '0; m_err = 0; m_run = 0; m_ovf = '0;
  endtask

  task automatic model_update(input logic [NUB-1:0] iv, input logic [DW-1:0] id,
                              input logic ordy, input logic fl);
    bit any_ne, all_ne, partial, do_pop;
    bit [NUB-1:0] was_full;
    any_ne = 0;
    all_ne = 1;
    for (int j = 0; j < NUB; j++) begin
      if (mq[j].size() != 0) any_ne = 1; else all_ne = 0;
      was_full[j] = (mq[j].size() == DEPTH);
    end
    partial = any_ne && !all_ne;
    if (fl) begin
      for (int j = 0; j < NUB; j++) mq[j].delete();
      m_ov = 0; m_err = 0; m_run = 0; m_ovf = '0;
      return;
    end
    do_pop = all_ne && (!m_ov || ordy) && !m_err;
    if (!m_err) begin
      if (partial) begin
        m_run++;
        if (m_run > MAX_SKEW) m_err = 1;
      end else begin
        m_run = 0;
      end
    end
    if (do_pop) begin
      for (int j = 0; j < NUB; j++) m_od[j*WIDTH +: WIDTH] = mq[j].pop_front();
      m_ov = 1;
    end else if (m_ov && ordy) begin
      m_ov = 0;
    end
    for (int j = 0; j < NUB; j++) begin
      if (iv[j]) begin
        if (was_full[j]) m_ovf[j] = 1;
        else mq[j].push_back(id[j*WIDTH +: WIDTH]);
      end
    end
  endtask

  task automatic compare_all();
    logic [NUB-1:0] exp_rdy;
    for (int j = 0; j < NUB; j++) exp_rdy[j] = (mq[j].size() < DEPTH);
    check("out_valid", out_valid, m_ov);
    if (m_ov) check("out_data", out_data, m_od);
    check("in_ready", in_ready, exp_rdy);
    check("err_skew", err_skew, m_err);
    check("err_ovf", err_ovf, m_ovf);
  endtask

  task automatic step(input logic [NUB-1:0] iv, input logic [DW-1:0] id,
                      input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_update(iv, id, ordy, fl);
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_in_ready"}, in_ready, {NUB{1'b1}});
    check({tag, "_err_skew"}, err_skew, 1'b0);
    check({tag, "_err_ovf"}, err_ovf, '0);
  endtask

  int nwords;
  int wr_at [NUB][NWRAP];
  int idx [NUB];

  initial begin
    rst_n = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #11;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned stream
    nwords = 0;
    for (int k = 0; k < 10; k++) begin
      step('1, word(k), 1'b1, 1'b0);
      if (out_valid) nwords++;
    end
    for (int k = 0; k < 4; k++) begin
      step('0, '0, 1'b1, 1'b0);
      if (out_valid) nwords++;
    end
    check("aligned_count", nwords, 10);

    // Tolerated skew: lanes 1-3 arrive MAX_SKEW cycles after lane 0
    step(4'b0001, 32'h0000_00A0, 1'b1, 1'b0);
    for (int k = 1; k < MAX_SKEW; k++) step('0, '0, 1'b1, 1'b0);
    step(4'b1110, 32'hA3A2_A100, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    check("skew_ok_valid", out_valid, 1'b1);
    check("skew_ok_data", out_data, 32'hA3A2_A1A0);
    check("skew_ok_err", err_skew, 1'b0);
    step('0, '0, 1'b1, 1'b0);

    // Skew timeout: one cycle too late
    step(4'b0001, 32'h0000_00B0, 1'b1, 1'b0);
    for (int k = 1; k <= MAX_SKEW; k++) step('0, '0, 1'b1, 1'b0);
    step(4'b1110, 32'hB3B2_B100, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    check("timeout_err", err_skew, 1'b1);
    check("timeout_no_valid", out_valid, 1'b0);
    step('0, '0, 1'b1, 1'b1);
    check("flush_err", err_skew, 1'b0);
    check("flush_ready", in_ready, {NUB{1'b1}});
    step('1, word(5), 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    check("post_flush_data", out_data, word(5));
    step('0, '0, 1'b1, 1'b0);

    // Backpressure and overflow
    for (int k = 0; k < 10; k++) step('1, word(k), 1'b0, 1'b0);
    check("bp_ovf", err_ovf, {NUB{1'b1}});
    check("bp_ready", in_ready, '0);
    check("bp_hold", out_data, word(0));
    nwords = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin
        check("drain_data", out_data, word(nwords));
        nwords++;
      end
      step('0, '0, 1'b1, 1'b0);
    end
    check("drain_count", nwords, 9);
    step('0, '0, 1'b1, 1'b1);

    // Wrap-around with random per-lane skew of 0..3 cycles
    for (int j = 0; j < NUB; j++) begin
      idx[j] = 0;
      for (int k = 0; k < NWRAP; k++) wr_at[j][k] = 4 * k + int'($urandom_range(0, 3));
    end
    nwords = 0;
    for (int t = 0; t < 4 * NWRAP + 20; t++) begin
      logic [NUB-1:0] iv;
      logic [DW-1:0]  id;
      logic           ordy;
      iv = '0;
      id = '0;
      for (int j = 0; j < NUB; j++) begin
        if (idx[j] < NWRAP && wr_at[j][idx[j]] == t) begin
          iv[j] = 1'b1;
          id[j*WIDTH +: WIDTH] = WIDTH'(16 * j + idx[j]);
          idx[j]++;
        end
      end
      ordy = (t >= 4 * NWRAP) ? 1'b1 : 1'($urandom_range(0, 1));
      if (out_valid && ordy) nwords++;
      step(iv, id, ordy, 1'b0);
    end
    check("wrap_count", nwords, NWRAP);
    check("wrap_err_skew", err_skew, 1'b0);
    check("wrap_err_ovf", err_ovf, '0);

    // Unconstrained random traffic with occasional flush
    for (int t = 0; t < 300; t++) begin
      step(NUB'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 31) == 0));
    end

    // Async reset mid-stream
    step('0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) step('1, word(k), 1'b0, 1'b0);
    check("pre_reset_valid", out_valid, 1'b1);
    in_valid = '0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("midreset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step('0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
